// File: rtl/cp0_exception_unit_if.sv
// CP0 pipeline-side bundle: M-stage exception inputs, mtc0/mfc0 access, interrupt lines.
// Latency: carries no state; req and cp0_rdata are combinational from the slave side.
// Backpressure: none, a taken req is acted on by the pipeline in the same cycle.
interface cp0_exception_unit_if #(
  parameter int IM_WIDTH = 6
);
  logic                en;
  logic [4:0]          cp0_addr;
  logic [31:0]         cp0_wdata;
  logic [31:0]         cp0_rdata;
  logic [31:0]         vpc;
  logic                BD_in;
  logic [4:0]          exc_code_in;
  logic [IM_WIDTH-1:0] hw_int;
  logic                exl_clr;
  logic                req;
  logic [31:0]         epc_out;

  // Pipeline / interrupt-controller side drives the M-stage state.
  modport master (
    output en, cp0_addr, cp0_wdata, vpc, BD_in, exc_code_in, hw_int, exl_clr,
    input  cp0_rdata, req, epc_out
  );

  // CP0 side consumes the M-stage state and reports the flush request.
  modport slave (
    input  en, cp0_addr, cp0_wdata, vpc, BD_in, exc_code_in, hw_int, exl_clr,
    output cp0_rdata, req, epc_out
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: merges M-stage exceptions with hw interrupts, holds SR/Cause/EPC.
// Latency: req and mfc0 reads combinational; interrupts seen 1 cycle after hw_int (registered IP).
// Backpressure: none; a taken req overrides any same-cycle mtc0. Optional timer: CP0_TIMER_EN.
module cp0_exception_unit #(
  parameter logic [4:0] NO_EXC   = 5'd31,
  parameter int         IM_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_exception_unit_if.slave  bus
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  // Architectural state
  logic [IM_WIDTH-1:0] sr_im_q,    sr_im_d;
  logic                sr_exl_q,   sr_exl_d;
  logic                sr_ie_q,    sr_ie_d;
  logic                cause_bd_q, cause_bd_d;
  logic [IM_WIDTH-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]          cause_exc_q, cause_exc_d;
  logic [31:0]         epc_q,      epc_d;

  logic [IM_WIDTH-1:0] hw_int_eff;
  logic                int_pend;
  logic                exc_pend;
  logic                take;
  logic                wr_sr;
  logic                wr_epc;
  logic [31:0]         sr_val;
  logic [31:0]         cause_val;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q,      ti_d;
  logic        wr_count;
  logic        wr_compare;
`endif

  // Pending conditions; EXL masks both sources so nested events are ignored.
  always_comb begin
    int_pend = (|(cause_ip_q & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_pend = (bus.exc_code_in != NO_EXC) & ~sr_exl_q;
    take     = ~reset & (int_pend | exc_pend);
  end

  assign bus.req     = take;
  assign bus.epc_out = epc_q;

  // mtc0 strobes; a taken exception discards any same-cycle write.
  always_comb begin
    wr_sr  = bus.en & ~take & (bus.cp0_addr == ADDR_SR);
    wr_epc = bus.en & ~take & (bus.cp0_addr == ADDR_EPC);
  end

`ifdef CP0_TIMER_EN
  // Timer strobes and next state: Count free-runs unless written, TI is sticky until Compare is written.
  always_comb begin
    wr_count   = bus.en & ~take & (bus.cp0_addr == ADDR_COUNT);
    wr_compare = bus.en & ~take & (bus.cp0_addr == ADDR_COMPARE);
    count_d    = wr_count   ? bus.cp0_wdata : (count_q + 32'd1);
    compare_d  = wr_compare ? bus.cp0_wdata : compare_q;
    if (wr_compare) begin
      ti_d = 1'b0;
    end else begin
      ti_d = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
    end
  end

  // Timer interrupt rides on the top interrupt line ahead of the IP register.
  always_comb begin
    hw_int_eff               = bus.hw_int;
    hw_int_eff[IM_WIDTH-1]   = bus.hw_int[IM_WIDTH-1] | ti_q;
  end
`else
  // No timer: interrupt lines feed IP directly.
  always_comb begin
    hw_int_eff = bus.hw_int;
  end
`endif

  // Next-state for SR/Cause/EPC: exception entry outranks mtc0 and eret.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int_eff;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (take) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_pend ? 5'd0 : bus.exc_code_in;
      cause_bd_d  = bus.BD_in;
      epc_d       = bus.BD_in ? (bus.vpc - 32'd4) : bus.vpc;
    end else begin
      if (wr_sr) begin
        sr_im_d  = bus.cp0_wdata[10 +: IM_WIDTH];
        sr_exl_d = bus.cp0_wdata[1];
        sr_ie_d  = bus.cp0_wdata[0];
      end
      if (wr_epc) begin
        epc_d = bus.cp0_wdata;
      end
      // eret lands after any same-cycle SR write so EXL always ends up clear.
      if (bus.exl_clr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

`ifdef CP0_TIMER_EN
  // Timer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`endif

  // Architectural views of SR and Cause; unlisted bits read as zero.
  always_comb begin
    sr_val                    = 32'd0;
    sr_val[10 +: IM_WIDTH]    = sr_im_q;
    sr_val[1]                 = sr_exl_q;
    sr_val[0]                 = sr_ie_q;
    cause_val                 = 32'd0;
    cause_val[31]             = cause_bd_q;
    cause_val[10 +: IM_WIDTH] = cause_ip_q;
    cause_val[6:2]            = cause_exc_q;
  end

  // mfc0 read mux: pre-edge register values, no bypass of a same-cycle write.
  always_comb begin
    bus.cp0_rdata = 32'd0;
    case (bus.cp0_addr)
      ADDR_SR:      bus.cp0_rdata = sr_val;
      ADDR_CAUSE:   bus.cp0_rdata = cause_val;
      ADDR_EPC:     bus.cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   bus.cp0_rdata = count_q;
      ADDR_COMPARE: bus.cp0_rdata = compare_q;
`endif
      default:      bus.cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;

  logic clk;
  logic reset;
  int   total;
  int   fails;

  cp0_exception_unit_if #(.IM_WIDTH(6)) bus ();

  cp0_exception_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational mfc0 read of one register, taken mid-cycle.
  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.cp0_addr = addr;
    #1;
    chk(tag, bus.cp0_rdata, exp);
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    reset           = 1'b1;
    bus.en          = 1'b0;
    bus.cp0_addr    = 5'd0;
    bus.cp0_wdata   = 32'd0;
    bus.vpc         = 32'd0;
    bus.BD_in       = 1'b0;
    bus.exc_code_in = 5'd4;
    bus.hw_int      = 6'h3F;
    bus.exl_clr     = 1'b0;

    // Reset with exception and interrupts asserted: req must stay low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("req_in_reset", {31'd0, bus.req}, 32'd0);
    end
    step();
    reset           = 1'b0;
    bus.exc_code_in = 5'd31;
    bus.hw_int      = 6'h00;
    @(negedge clk);
    chk("req_after_reset", {31'd0, bus.req}, 32'd0);
    rd("sr_reset", 5'd12, 32'h0);
    rd("cause_reset", 5'd13, 32'h0);
    rd("epc_reset", 5'd14, 32'h0);
    chk("epc_out_reset", bus.epc_out, 32'h0);

    // mtc0 SR then a synchronous exception, not in a delay slot.
    step();
    bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000FC01;
    step();
    bus.en = 1'b0; bus.exc_code_in = 5'd10; bus.vpc = 32'h3010; bus.BD_in = 1'b0;
    @(negedge clk);
    chk("req_exc10", {31'd0, bus.req}, 32'd1);
    step();
    bus.exc_code_in = 5'd31;
    @(negedge clk);
    rd("cause_exc10", 5'd13, 32'h00000028);
    rd("epc_exc10", 5'd14, 32'h00003010);
    chk("epc_out_exc10", bus.epc_out, 32'h00003010);
    rd("sr_exl_set", 5'd12, 32'h0000FC03);
    chk("req_masked_exl", {31'd0, bus.req}, 32'd0);

    // eret, then the same exception from a delay slot.
    step();
    bus.exl_clr = 1'b1;
    step();
    bus.exl_clr = 1'b0;
    @(negedge clk);
    rd("sr_after_eret", 5'd12, 32'h0000FC01);
    step();
    bus.exc_code_in = 5'd10; bus.vpc = 32'h3014; bus.BD_in = 1'b1;
    @(negedge clk);
    chk("req_exc_bd", {31'd0, bus.req}, 32'd1);
    step();
    bus.exc_code_in = 5'd31; bus.BD_in = 1'b0;
    @(negedge clk);
    rd("cause_bd", 5'd13, 32'h80000028);
    rd("epc_bd", 5'd14, 32'h00003010);

    // eret with SR write in the same cycle: written EXL=1 is overridden to 0.
    step();
    bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h00000403; bus.exl_clr = 1'b1;
    step();
    bus.en = 1'b0; bus.exl_clr = 1'b0; bus.hw_int = 6'h01; bus.vpc = 32'h3020;
    @(negedge clk);
    rd("sr_write_eret", 5'd12, 32'h00000401);
    chk("req_ip_latency", {31'd0, bus.req}, 32'd0);
    step();
    bus.exc_code_in = 5'd12;
    @(negedge clk);
    chk("req_int", {31'd0, bus.req}, 32'd1);
    step();
    bus.exc_code_in = 5'd4;
    @(negedge clk);
    rd("cause_int_wins", 5'd13, 32'h00000400);
    rd("epc_int", 5'd14, 32'h00003020);
    chk("req_nested_masked", {31'd0, bus.req}, 32'd0);

    // eret with hw_int low; a write to Cause is ignored.
    step();
    bus.hw_int = 6'h00; bus.exc_code_in = 5'd31; bus.exl_clr = 1'b1;
    bus.en = 1'b1; bus.cp0_addr = 5'd13; bus.cp0_wdata = 32'hFFFFFFFF;
    step();
    bus.en = 1'b0; bus.exl_clr = 1'b0;
    @(negedge clk);
    rd("sr_eret_exl0", 5'd12, 32'h00000401);
    rd("cause_ro", 5'd13, 32'h00000000);
    chk("req_idle", {31'd0, bus.req}, 32'd0);

    // mtc0 EPC colliding with a taken exception is discarded.
    step();
    bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h00003400;
    bus.exc_code_in = 5'd10; bus.vpc = 32'h00005000;
    @(negedge clk);
    chk("req_vs_mtc0", {31'd0, bus.req}, 32'd1);
    step();
    bus.en = 1'b0; bus.exc_code_in = 5'd31;
    @(negedge clk);
    chk("epc_out_not_mtc0", bus.epc_out, 32'h00005000);
    rd("cause_exc10_b", 5'd13, 32'h00000028);

    // mtc0 EPC accepted while EXL=1, together with eret.
    step();
    bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h00001234; bus.exl_clr = 1'b1;
    #1;
    chk("rdata_no_bypass", bus.cp0_rdata, 32'h00005000);
    step();
    bus.en = 1'b0; bus.exl_clr = 1'b0;
    @(negedge clk);
    chk("epc_out_mtc0", bus.epc_out, 32'h00001234);
    rd("sr_exl_clear2", 5'd12, 32'h00000401);
    rd("unmapped_0", 5'd0, 32'h0);
    rd("unmapped_15", 5'd15, 32'h0);

    // Delay-slot exception at PC 0: EPC wraps.
    step();
    bus.exc_code_in = 5'd2; bus.vpc = 32'h0; bus.BD_in = 1'b1;
    step();
    bus.exc_code_in = 5'd31; bus.BD_in = 1'b0;
    @(negedge clk);
    chk("epc_wrap", bus.epc_out, 32'hFFFFFFFC);
    rd("cause_wrap", 5'd13, 32'h80000008);

`ifdef CP0_TIMER_EN
    // Timer: Count/Compare raise TI on hw_int[5].
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h00008001;
    step();
    bus.cp0_addr = 5'd9; bus.cp0_wdata = 32'd0;
    step();
    bus.cp0_addr = 5'd11; bus.cp0_wdata = 32'd5;
    step();
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("req_timer_wait", {31'd0, bus.req}, 32'd0);
      step();
    end
    @(negedge clk);
    chk("req_timer", {31'd0, bus.req}, 32'd1);
    rd("count_at_req", 5'd9, 32'd7);
    step();
    @(negedge clk);
    rd("cause_timer", 5'd13, 32'h00008000);
    step();
    bus.en = 1'b1; bus.cp0_addr = 5'd11; bus.cp0_wdata = 32'd0;
    step();
    bus.en = 1'b0;
    step();
    @(negedge clk);
    rd("cause_ti_clear", 5'd13, 32'h00000000);
`endif

    step();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
